// File: rtl/encoder_pkg.sv
// encoder_pkg: shared widths, index type and bit-count helper for the 4-to-2 encoder
package encoder_pkg;
  localparam int IN_W  = 4;
  localparam int OUT_W = 2;
  typedef logic [OUT_W-1:0] idx_t;
  function automatic logic [2:0] popcount4(input logic [IN_W-1:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction
endpackage

// File: rtl/encoder_4x2_core.sv
// encoder_4x2_core: combinational one-hot / priority encode with invalid-case flags
module encoder_4x2_core
  import encoder_pkg::*;
#(
  parameter bit PRIORITY = 1'b0
) (
  input  logic [IN_W-1:0] in,
  output idx_t            out,
  output logic            valid,
  output logic            none,
  output logic            multi
);
  logic [2:0] cnt;
  idx_t       hi;
  always_comb begin
    cnt   = popcount4(in);
    hi    = in[3] ? 2'd3 : in[2] ? 2'd2 : in[1] ? 2'd1 : 2'd0;
    none  = cnt == 3'd0;
    multi = cnt > 3'd1;
    valid = PRIORITY ? !none : cnt == 3'd1;
    out   = valid ? hi : '0;
  end
endmodule

// File: rtl/encoder_4x2.sv
// encoder_4x2: 4-to-2 encoder with optional registered outputs and sync reset
module encoder_4x2
  import encoder_pkg::*;
#(
  parameter bit PRIORITY   = 1'b0,
  parameter bit REGISTERED = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] in,
  output idx_t            out,
  output logic            valid,
  output logic            none,
  output logic            multi
);
  idx_t c_out;
  logic c_valid, c_none, c_multi;
  encoder_4x2_core #(.PRIORITY(PRIORITY)) u_core (
    .in(in), .out(c_out), .valid(c_valid), .none(c_none), .multi(c_multi)
  );
  if (REGISTERED) begin : g_reg
    idx_t out_d, out_q;
    logic valid_d, valid_q, none_d, none_q, multi_d, multi_q;
    always_comb begin
      out_d   = rst ? '0 : c_out;
      valid_d = rst ? 1'b0 : c_valid;
      none_d  = rst ? 1'b0 : c_none;
      multi_d = rst ? 1'b0 : c_multi;
    end
    always_ff @(posedge clk) begin
      out_q   <= out_d;
      valid_q <= valid_d;
      none_q  <= none_d;
      multi_q <= multi_d;
    end
    assign {out, valid, none, multi} = {out_q, valid_q, none_q, multi_q};
  end else begin : g_comb
    // clk and rst are intentionally unused when the outputs are combinational
    logic unused_clk_rst;
    assign unused_clk_rst = ^{clk, rst};
    assign {out, valid, none, multi} = {c_out, c_valid, c_none, c_multi};
  end
endmodule

// File: tb/tb_encoder_4x2.sv
// tb_encoder_4x2: strict, priority and combinational builds checked against a bit-counting model
module tb_encoder_4x2;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in  = 4'b1000;
  logic [1:0] out_s, out_p, out_c;
  logic       valid_s, none_s, multi_s;
  logic       valid_p, none_p, multi_p;
  logic       valid_c, none_c, multi_c;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  encoder_4x2 #(.PRIORITY(1'b0), .REGISTERED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .in(in), .out(out_s), .valid(valid_s), .none(none_s), .multi(multi_s));
  encoder_4x2 #(.PRIORITY(1'b1), .REGISTERED(1'b1)) dut_p (
    .clk(clk), .rst(rst), .in(in), .out(out_p), .valid(valid_p), .none(none_p), .multi(multi_p));
  encoder_4x2 #(.PRIORITY(1'b1), .REGISTERED(1'b0)) dut_c (
    .clk(clk), .rst(rst), .in(in), .out(out_c), .valid(valid_c), .none(none_c), .multi(multi_c));

  // Returns {out, valid, none, multi} from counting set bits and finding the top one.
  function automatic logic [4:0] model(input bit prio, input logic [3:0] v);
    int n = 0;
    logic [1:0] h = 2'd0;
    for (int i = 0; i < 4; i++)
      if (v[i]) begin
        n++;
        h = 2'(i);
      end
    if (n == 0) return 5'b00_0_1_0;
    if (n == 1) return {h, 3'b1_0_0};
    return prio ? {h, 3'b1_0_1} : 5'b00_0_0_1;
  endfunction

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s in=%b rst=%b got {out,valid,none,multi}=%b expected %b", tag, in, rst, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] v);
    @(negedge clk);
    rst = r;
    in  = v;
    #1 check("comb", {out_c, valid_c, none_c, multi_c}, model(1'b1, v));
    @(posedge clk);
    #1;
    check("strict", {out_s, valid_s, none_s, multi_s}, r ? 5'b0 : model(1'b0, v));
    check("prio", {out_p, valid_p, none_p, multi_p}, r ? 5'b0 : model(1'b1, v));
  endtask

  initial begin
    step(1'b1, 4'b1000);
    step(1'b1, 4'b1000);
    foreach (in[i]) step(1'b0, 4'b0001 << i);
    step(1'b0, 4'b0000);
    step(1'b0, 4'b1111);
    step(1'b0, 4'b0011);
    step(1'b0, 4'b0101);
    step(1'b0, 4'b0110);
    step(1'b0, 4'b0100);
    step(1'b1, 4'b0100);
    step(1'b0, 4'b0100);
    for (int v = 0; v < 16; v++) step(1'b0, 4'(v));
    for (int k = 0; k < 300; k++) step(($urandom_range(0, 19) == 0), 4'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
